// File: rtl/fir_sample_capture.sv
// Output-side capture buffer for the FIR chain: skips the pipeline-fill samples, stores DEPTH samples, drains them in order.
// Optional peak tracking (peak_max/peak_min) is compiled in when CAPTURE_PEAK_EN is defined.
module fir_sample_capture #(
    parameter int DW    = 32,
    parameter int DEPTH = 1000,
    parameter int AW    = 10,
    parameter int SKIP  = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done
`ifdef CAPTURE_PEAK_EN
    ,
    output logic [DW-1:0] peak_max,
    output logic [DW-1:0] peak_min
`endif
);

    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [SW-1:0] LAST_SKIP = SW'(SKIP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    state_t        state_r;
    state_t        next_s;
    logic          run_start_s;
    logic          wr_en_s;
    logic          rd_accept_s;
    logic [SW-1:0] skip_cnt_r;
    logic [AW-1:0] wr_addr_r;
    logic [AW-1:0] rd_addr_r;
    logic [DW-1:0] rd_data_r;
    logic          rd_valid_r;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] mem_r [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        next_s      = state_r;
        run_start_s = 1'b0;
        wr_en_s     = 1'b0;
        rd_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    run_start_s = 1'b1;
                    if (SKIP == 0) begin
                        next_s = ST_CAPTURE;
                    end else begin
                        next_s = ST_SKIP;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (skip_cnt_r == LAST_SKIP) begin
                    next_s = ST_CAPTURE;
                end else begin
                    next_s = ST_SKIP;
                end
            end
            ST_CAPTURE: begin
                wr_en_s = 1'b1;
                if (wr_addr_r == LAST_ADDR) begin
                    next_s = ST_READ;
                end else begin
                    next_s = ST_CAPTURE;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    rd_accept_s = 1'b1;
                    if (rd_addr_r == LAST_ADDR) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_READ;
                    end
                end else begin
                    next_s = ST_READ;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Skip counter and write/read address counters; addresses saturate at DEPTH-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_cnt_r <= {SW{1'b0}};
            wr_addr_r  <= {AW{1'b0}};
            rd_addr_r  <= {AW{1'b0}};
        end else begin
            if (run_start_s) begin
                skip_cnt_r <= {SW{1'b0}};
                wr_addr_r  <= {AW{1'b0}};
            end else begin
                if ((state_r == ST_SKIP) && (skip_cnt_r != LAST_SKIP)) begin
                    skip_cnt_r <= skip_cnt_r + SW'(1'b1);
                end
                if (wr_en_s && (wr_addr_r != LAST_ADDR)) begin
                    wr_addr_r <= wr_addr_r + AW'(1'b1);
                end
            end
            if (wr_en_s && (wr_addr_r == LAST_ADDR)) begin
                rd_addr_r <= {AW{1'b0}};
            end else if (rd_accept_s && (rd_addr_r != LAST_ADDR)) begin
                rd_addr_r <= rd_addr_r + AW'(1'b1);
            end
        end
    end

    // Sample RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_r] <= data_in;
        end
    end

    // Registered read port; rd_data holds between accepted reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r  <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_data_r <= mem_r[rd_addr_r];
            end
        end
    end

    // Status flags registered from the next state so they line up with the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s == ST_SKIP) || (next_s == ST_CAPTURE);
            done_r <= (next_s == ST_READ);
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef CAPTURE_PEAK_EN
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] peak_max_r;
    logic [DW-1:0] peak_min_r;

    // Signed running extremes of captured samples, re-armed at each run start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_max_r <= MOST_NEG;
            peak_min_r <= MOST_POS;
        end else if (run_start_s) begin
            peak_max_r <= MOST_NEG;
            peak_min_r <= MOST_POS;
        end else if (wr_en_s) begin
            if ($signed(data_in) > $signed(peak_max_r)) begin
                peak_max_r <= data_in;
            end
            if ($signed(data_in) < $signed(peak_min_r)) begin
                peak_min_r <= data_in;
            end
        end
    end

    assign peak_max = peak_max_r;
    assign peak_min = peak_min_r;
`endif

endmodule

// File: tb/tb_fir_sample_capture.sv
// Scoreboard bench for fir_sample_capture: directed runs push expected reads, a negedge monitor pops and compares.
module tb_fir_sample_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int SKIP  = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = {DW{1'b0}};
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
`ifdef CAPTURE_PEAK_EN
    logic [DW-1:0] peak_max;
    logic [DW-1:0] peak_min;
`endif

    fir_sample_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .SKIP(SKIP)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done)
`ifdef CAPTURE_PEAK_EN
        ,
        .peak_max (peak_max),
        .peak_min (peak_min)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            mode = 0;
    int            k = 0;
    logic [DW-1:0] last_exp = {DW{1'b0}};

    // mode 0: ramp (value = cycles since start edge); 1: +big / -123456 alternating; 2: zeros
    function automatic logic [DW-1:0] sample_val(input int m, input int idx);
        case (m)
            1:       return ((idx % 2) == 0) ? 32'h7FFF_FFF0 : 32'hFFFE_1DC0;
            2:       return 32'h0000_0000;
            default: return DW'(idx);
        endcase
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        data_in = sample_val(mode, k);
    endtask

    task automatic begin_run(input int m);
        mode    = m;
        k       = 0;
        data_in = sample_val(m, 0);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_capture(input bit inject);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            if (inject) begin
                start = (n == 600);
                rd_en = (n >= 5 && n < 9);
            end
            tick();
            n++;
        end
        start = 1'b0;
        rd_en = 1'b0;
        check("busy_cycles", DW'(n), DW'(SKIP + DEPTH));
        check("done_after_capture", {31'd0, done}, 32'd1);
    endtask

    task automatic drain(input int stride, input bit start_on_last, input bit extra_rd);
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 1; s < stride; s++) begin
                rd_en = 1'b0;
                tick();
            end
            rd_en = 1'b1;
            if (start_on_last && i == DEPTH - 1) start = 1'b1;
            sb.push_back('{sample_val(mode, SKIP + 1 + i), cyc + 1});
            tick();
            start = 1'b0;
        end
        if (extra_rd) begin
            rd_en = 1'b1;
            tick();
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        check("done_after_drain", {31'd0, done}, 32'd0);
        check("busy_after_drain", {31'd0, busy}, 32'd0);
        check("sb_empty", DW'(sb.size()), 32'd0);
    endtask

    // Monitor: every rd_valid must match the next queued read; otherwise rd_data must hold
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_exp = {DW{1'b0}};
        end else if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_data %h with no read outstanding (t=%0t)", rd_data, $time);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_latency", DW'(cyc), DW'(e.cyc));
                last_exp = e.data;
            end
        end else begin
            check("rd_data_hold", rd_data, last_exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with toggling data
        repeat (3) tick();
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef CAPTURE_PEAK_EN
        check("rst_peak_max", peak_max, 32'h8000_0000);
        check("rst_peak_min", peak_min, 32'h7FFF_FFFF);
`endif
        rst = 1'b1;
        repeat (5) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        // run A: ramp, continuous drain, reads after the last one ignored
        begin_run(0);
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_capture(1'b0);
        drain(1, 1'b0, 1'b1);

        // run B: ignored start in CAPTURE and rd_en in SKIP, throttled drain, start with last read
        begin_run(0);
        wait_capture(1'b1);
        drain(3, 1'b1, 1'b0);
        repeat (3) tick();
        check("idle_after_last_start", {31'd0, busy}, 32'd0);

        // run C: asynchronous reset after 500 captured samples, then a clean run
        begin_run(0);
        repeat (SKIP + 500) tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        #4;
        rst = 1'b1;
        tick();
        begin_run(0);
        wait_capture(1'b0);
        drain(1, 1'b0, 1'b0);

`ifdef CAPTURE_PEAK_EN
        // run D: peak tracking, then re-arm on an all-zero run
        begin_run(1);
        wait_capture(1'b0);
        check("peak_max_alt", peak_max, 32'h7FFF_FFF0);
        check("peak_min_alt", peak_min, 32'hFFFE_1DC0);
        drain(1, 1'b0, 1'b0);
        check("peak_max_hold", peak_max, 32'h7FFF_FFF0);
        check("peak_min_hold", peak_min, 32'hFFFE_1DC0);
        begin_run(2);
        wait_capture(1'b0);
        check("peak_max_zero", peak_max, 32'h0000_0000);
        check("peak_min_zero", peak_min, 32'h0000_0000);
        drain(1, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
